// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative read cache with true-LRU replacement,
// multi-beat line refill and write-through, no-write-allocate stores.
module cache_ctrl_nway #(
    parameter int ADDR_W   = 18,
    parameter int WORD_W   = 32,
    parameter int SET_BITS = 6,
    parameter int OFF_BITS = 1,
    parameter int WAYS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W = ADDR_W - SET_BITS - OFF_BITS;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WPL   = 1 << OFF_BITS;
    localparam int WAY_B = $clog2(WAYS);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_FLUSH} state_t;

    state_t              r_state, w_next;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [WAY_B-1:0]    r_age   [SETS][WAYS];
    logic [WORD_W-1:0]   r_data  [SETS][WAYS][WPL];
    logic [OFF_BITS-1:0] r_beat;
    logic [WAY_B-1:0]    r_victim;
    logic                r_refilled;
    logic [15:0]         r_hit_cnt, r_miss_cnt;

    logic [TAG_W-1:0]    w_tag;
    logic [SET_BITS-1:0] w_idx;
    logic [OFF_BITS-1:0] w_off;
    logic                w_hit, w_rd_hit, w_rd_miss, w_wr_done, w_install, w_touch;
    logic [WAY_B-1:0]    w_hit_way, w_victim, w_touch_way, w_old_age;

    assign w_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = cpu_addr[OFF_BITS +: SET_BITS];
    assign w_off = cpu_addr[OFF_BITS-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int j = 0; j < WAYS; j++)
            if (r_valid[w_idx][j] && r_tag[w_idx][j] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_B'(j);
            end
    end

    // Lowest invalid way wins; otherwise the way holding the oldest rank.
    always_comb begin
        w_victim = '0;
        for (int j = WAYS - 1; j >= 0; j--)
            if (r_age[w_idx][j] == WAY_B'(WAYS - 1)) w_victim = WAY_B'(j);
        for (int j = WAYS - 1; j >= 0; j--)
            if (!r_valid[w_idx][j]) w_victim = WAY_B'(j);
    end

    assign w_rd_hit    = r_state == S_IDLE && !flush && cpu_rd_en && !cpu_wr_en && w_hit;
    assign w_rd_miss   = r_state == S_IDLE && !flush && cpu_rd_en && !cpu_wr_en && !w_hit;
    assign w_wr_done   = r_state == S_WRITE && mem_ready;
    assign w_install   = r_state == S_REFILL && mem_ready && &r_beat;
    assign w_touch     = w_rd_hit || w_install || (w_wr_done && w_hit);
    assign w_touch_way = w_install ? r_victim : w_hit_way;
    // A fresh install ages every other valid way, as if it came from the oldest rank.
    assign w_old_age   = w_install ? WAY_B'(WAYS - 1) : r_age[w_idx][w_hit_way];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = flush ? S_FLUSH : cpu_wr_en ? S_WRITE :
                               (cpu_rd_en && !w_hit) ? S_REFILL : S_IDLE;
            S_REFILL: w_next = w_install ? S_IDLE : S_REFILL;
            S_WRITE:  w_next = mem_ready ? S_IDLE : S_WRITE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = r_state == S_REFILL;
        mem_wr_en = r_state == S_WRITE;
        mem_addr  = r_state == S_REFILL ? {w_tag, w_idx, r_beat} : cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = rst && (w_rd_hit || w_wr_done);
        cpu_rdata = r_data[w_idx][w_hit_way][w_off];
        hit_cnt   = r_hit_cnt;
        miss_cnt  = r_miss_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int j = 0; j < WAYS; j++) r_age[s][j] <= '0;
            end
            r_beat     <= '0;
            r_victim   <= '0;
            r_refilled <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refilled <= w_install;
            if (w_rd_miss) begin
                r_victim   <= w_victim;
                r_miss_cnt <= r_miss_cnt + 16'(~&r_miss_cnt);
            end
            // The hit that completes a refill is the same request as the miss.
            if (w_rd_hit && !r_refilled) r_hit_cnt <= r_hit_cnt + 16'(~&r_hit_cnt);
            if (r_state == S_REFILL && mem_ready) r_beat <= r_beat + 1'b1;
            if (w_install) r_valid[w_idx][r_victim] <= 1'b1;
            if (w_touch)
                for (int j = 0; j < WAYS; j++)
                    r_age[w_idx][j] <= WAY_B'(j) == w_touch_way ? '0 :
                        r_age[w_idx][j] + WAY_B'(r_age[w_idx][j] < w_old_age);
            if (r_state == S_FLUSH)
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                    for (int j = 0; j < WAYS; j++) r_age[s][j] <= '0;
                end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && mem_ready) r_data[w_idx][r_victim][r_beat] <= mem_rdata;
        if (w_wr_done && w_hit) r_data[w_idx][w_hit_way][w_off] <= cpu_wdata;
        if (w_install) r_tag[w_idx][r_victim] <= w_tag;
    end
endmodule
